// File: rtl/ge_feeder.sv
// Row feeder for a Gaussian-elimination array: streams DAT_D rows in triangularize mode,
// then triggers systemize mode. Define GE_FEEDER_CYCLE_CNT_EN to add the run-length counter.
module ge_feeder #(
   parameter int unsigned DAT_W  = 8,
   parameter int unsigned DAT_D  = 8,
   parameter int unsigned ADDR_W = (DAT_D > 1) ? $clog2(DAT_D) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   input  logic [DAT_W-1:0]  mem_q,
   output logic              sa_mode,
   output logic              sa_start,
   output logic [DAT_W-1:0]  sa_data,
   input  logic              sa_finish,
   input  logic              sa_full_rank,
   output logic              busy,
   output logic              done,
   output logic              full_rank,
   output logic [31:0]       cycles
);

   typedef enum logic [2:0] {
      StIdle,
      StPrefetch,
      StStream,
      StWaitTri,
      StSysStart,
      StWaitSys,
      StDone
   } state_e;

   localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(DAT_D - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              fin_q;
   logic              mode_q, mode_d;
   logic              rank_q, rank_d;
   logic              fin_rise;
   logic              last_row;

   assign fin_rise = sa_finish & ~fin_q;
   assign last_row = (cnt_q == LastRow);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
         mode_q  <= 1'b0;
         rank_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fin_q   <= sa_finish;
         mode_q  <= mode_d;
         rank_q  <= rank_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      rank_d   = rank_q;
      mem_addr = '0;
      mem_rden = 1'b0;
      sa_start = 1'b0;
      sa_data  = '0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (go) begin
               state_d = StPrefetch;
               mode_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         StPrefetch: begin
            mem_rden = 1'b1;
            cnt_d    = '0;
            state_d  = StStream;
         end
         StStream: begin
            // Read data lags the address by one cycle, so the address runs one row ahead.
            sa_data  = mem_q;
            sa_start = (cnt_q == '0);
            if (!last_row) begin
               mem_addr = cnt_q + ADDR_W'(1);
               mem_rden = 1'b1;
               cnt_d    = cnt_q + ADDR_W'(1);
            end else begin
               mem_addr = LastRow;
               state_d  = StWaitTri;
            end
         end
         StWaitTri: begin
            if (fin_rise) begin
               rank_d  = sa_full_rank;
               mode_d  = 1'b1;
               state_d = StSysStart;
            end
         end
         StSysStart: begin
            sa_start = 1'b1;
            state_d  = StWaitSys;
         end
         StWaitSys: begin
            if (fin_rise) begin
               state_d = StDone;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign sa_mode   = mode_q;
   assign full_rank = rank_q;
   assign busy      = (state_q != StIdle);

`ifdef GE_FEEDER_CYCLE_CNT_EN
   logic [31:0] cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycles_q <= '0;
      end else if (state_q == StIdle) begin
         if (go) begin
            cycles_q <= '0;
         end
      end else begin
         cycles_q <= cycles_q + 32'd1;
      end
   end

   assign cycles = cycles_q;
`else
   assign cycles = '0;
`endif

endmodule

// File: tb/tb_ge_feeder.sv
// Scoreboard bench for ge_feeder: stimulus queues expected starts, rows and done pulses;
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ge_feeder;

   localparam int DatD = 8;
`ifdef GE_FEEDER_CYCLE_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   localparam int KStart = 0;
   localparam int KRow   = 1;
   localparam int KDone  = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [7:0]  data;
      logic        mode;
      logic        rank;
      logic [31:0] cnt;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [2:0]  mem_addr;
   logic        mem_rden;
   logic [7:0]  mem_q;
   logic        sa_mode;
   logic        sa_start;
   logic [7:0]  sa_data;
   logic        sa_finish;
   logic        sa_full_rank;
   logic        busy;
   logic        done;
   logic        full_rank;
   logic [31:0] cycles;

   logic [7:0]  rows [DatD] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   item_t       q [$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          win = 0;
   logic        exp_rank = 1'b0;
   item_t       it;

   ge_feeder dut (
      .clk          (clk),
      .rst          (rst),
      .go           (go),
      .mem_addr     (mem_addr),
      .mem_rden     (mem_rden),
      .mem_q        (mem_q),
      .sa_mode      (sa_mode),
      .sa_start     (sa_start),
      .sa_data      (sa_data),
      .sa_finish    (sa_finish),
      .sa_full_rank (sa_full_rank),
      .busy         (busy),
      .done         (done),
      .full_rank    (full_rank),
      .cycles       (cycles)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mem_rden) mem_q <= rows[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_cnt(input int n);
      return CntEn ? 32'(n) : 32'd0;
   endfunction

   task automatic push(input int kind, input int c, input logic [7:0] data, input logic mode,
                       input logic rank, input logic [31:0] cnt);
      item_t e;
      e.kind = kind;
      e.cyc  = c;
      e.data = data;
      e.mode = mode;
      e.rank = rank;
      e.cnt  = cnt;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk_all_zero(input string tag);
      @(negedge clk);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_rden"}, 32'(mem_rden), 32'd0);
      chk({tag, "_sa_mode"}, 32'(sa_mode), 32'd0);
      chk({tag, "_sa_start"}, 32'(sa_start), 32'd0);
      chk({tag, "_sa_data"}, 32'(sa_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_full_rank"}, 32'(full_rank), 32'd0);
      chk({tag, "_cycles"}, cycles, 32'd0);
   endtask

   // Pulses go in the current cycle and queues the first start plus the first nrows rows.
   task automatic start_matrix(input int nrows, output int t0);
      go = 1'b1;
      t0 = cyc;
      push(KStart, t0 + 2, rows[0], 1'b0, exp_rank, 32'd0);
      for (int k = 0; k < nrows; k++) push(KRow, t0 + 2 + k, rows[k], 1'b0, 1'b0, 32'd0);
      tick();
      go = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!busy) win = 0;
      if (sa_start) begin
         if (q.size() == 0 || q[0].kind != KStart) begin
            chk("unexpected_start", 32'(sa_start), 32'd0);
         end else begin
            it = q.pop_front();
            chk("start_cyc", cyc, it.cyc);
            chk("start_data", 32'(sa_data), 32'(it.data));
            chk("start_mode", 32'(sa_mode), 32'(it.mode));
            chk("start_rank", 32'(full_rank), 32'(it.rank));
            if (!it.mode) win = DatD;
         end
      end
      if (done) begin
         if (q.size() == 0 || q[0].kind != KDone) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            it = q.pop_front();
            chk("done_cyc", cyc, it.cyc);
            chk("done_mode", 32'(sa_mode), 32'(it.mode));
            chk("done_rank", 32'(full_rank), 32'(it.rank));
            chk("done_cycles", cycles, it.cnt);
         end
      end
      if (win > 0) begin
         if (q.size() == 0 || q[0].kind != KRow) begin
            chk("unexpected_row", 32'(win), 32'd0);
         end else begin
            it = q.pop_front();
            chk("row_cyc", cyc, it.cyc);
            chk("row_data", 32'(sa_data), 32'(it.data));
         end
         win--;
      end else begin
         chk("idle_data", 32'(sa_data), 32'd0);
      end
   end

   initial begin
      int t0;
      int t1;
      rst          = 1'b1;
      go           = 1'b0;
      sa_finish    = 1'b0;
      sa_full_rank = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      tick();
      rst = 1'b0;
      tick();

      // Finish held high from WAIT_TRI through SYS_START; done only after fall and re-rise.
      start_matrix(DatD, t0);
      run_to(t0 + 11);
      sa_finish    = 1'b1;
      sa_full_rank = 1'b0;
      exp_rank     = 1'b0;
      push(KStart, t0 + 12, 8'h00, 1'b1, 1'b0, 32'd0);
      run_to(t0 + 17);
      sa_finish = 1'b0;
      run_to(t0 + 19);
      sa_finish = 1'b1;
      push(KDone, t0 + 20, 8'h00, 1'b1, 1'b0, exp_cnt(19));
      run_to(t0 + 20);
      sa_finish = 1'b0;
      run_to(t0 + 21);
      @(negedge clk);
      chk("t2_idle_busy", 32'(busy), 32'd0);
      run_to(t0 + 25);

      // Address sequence, stray finish and go during STREAM, go during DONE.
      start_matrix(DatD, t0);
      for (int i = 1; i <= 10; i++) begin
         run_to(t0 + i);
         sa_finish = (i == 4);
         go        = (i == 5);
         @(negedge clk);
         if (i == 1) begin
            chk("pf_addr", 32'(mem_addr), 32'd0);
            chk("pf_rden", 32'(mem_rden), 32'd1);
         end else if (i <= 8) begin
            chk("st_addr", 32'(mem_addr), 32'(i - 1));
            chk("st_rden", 32'(mem_rden), 32'd1);
         end else begin
            chk("tail_rden", 32'(mem_rden), 32'd0);
            chk("tail_busy", 32'(busy), 32'd1);
         end
      end
      run_to(t0 + 12);
      sa_finish    = 1'b1;
      sa_full_rank = 1'b1;
      exp_rank     = 1'b1;
      push(KStart, t0 + 13, 8'h00, 1'b1, 1'b1, 32'd0);
      run_to(t0 + 13);
      sa_finish    = 1'b0;
      sa_full_rank = 1'b0;
      run_to(t0 + 16);
      sa_finish = 1'b1;
      push(KDone, t0 + 17, 8'h00, 1'b1, 1'b1, exp_cnt(16));
      run_to(t0 + 17);
      sa_finish = 1'b0;
      go        = 1'b1;
      run_to(t0 + 18);
      go = 1'b0;
      @(negedge clk);
      chk("t1_idle_busy", 32'(busy), 32'd0);
      chk("t1_idle_rden", 32'(mem_rden), 32'd0);
      chk("t1_idle_mode", 32'(sa_mode), 32'd1);
      chk("t1_idle_rank", 32'(full_rank), 32'd1);
      chk("t1_idle_cycles", cycles, exp_cnt(17));
      run_to(t0 + 22);

      // Reset at STREAM cycle 4, reset dominating go, then a clean restart.
      start_matrix(5, t0);
      run_to(t0 + 6);
      rst = 1'b1;
      run_to(t0 + 7);
      rst      = 1'b0;
      exp_rank = 1'b0;
      chk_all_zero("abort");
      run_to(t0 + 8);
      rst = 1'b1;
      go  = 1'b1;
      run_to(t0 + 9);
      rst = 1'b0;
      go  = 1'b0;
      @(negedge clk);
      chk("rstgo_busy", 32'(busy), 32'd0);
      chk("rstgo_rden", 32'(mem_rden), 32'd0);
      run_to(t0 + 10);
      start_matrix(DatD, t1);
      @(negedge clk);
      chk("restart_addr", 32'(mem_addr), 32'd0);
      chk("restart_rden", 32'(mem_rden), 32'd1);
      run_to(t1 + 11);
      sa_finish    = 1'b1;
      sa_full_rank = 1'b1;
      exp_rank     = 1'b1;
      push(KStart, t1 + 12, 8'h00, 1'b1, 1'b1, 32'd0);
      run_to(t1 + 12);
      sa_finish    = 1'b0;
      sa_full_rank = 1'b0;
      run_to(t1 + 14);
      sa_finish = 1'b1;
      push(KDone, t1 + 15, 8'h00, 1'b1, 1'b1, exp_cnt(14));
      run_to(t1 + 15);
      sa_finish = 1'b0;
      run_to(t1 + 18);

      // Array finishes 20 cycles after each start: 43 busy cycles precede DONE, 44 in total.
      start_matrix(DatD, t0);
      run_to(t0 + 22);
      sa_finish    = 1'b1;
      sa_full_rank = 1'b1;
      push(KStart, t0 + 23, 8'h00, 1'b1, 1'b1, 32'd0);
      run_to(t0 + 23);
      sa_finish = 1'b0;
      run_to(t0 + 43);
      sa_finish = 1'b1;
      push(KDone, t0 + 44, 8'h00, 1'b1, 1'b1, CntEn ? 32'd43 : 32'd0);
      run_to(t0 + 44);
      sa_finish    = 1'b0;
      sa_full_rank = 1'b0;
      run_to(t0 + 45);
      @(negedge clk);
      chk("cnt_after_done", cycles, CntEn ? 32'd44 : 32'd0);
      run_to(t0 + 48);
      @(negedge clk);
      chk("cnt_hold_idle", cycles, CntEn ? 32'd44 : 32'd0);

      run_to(cyc + 5);
      chk("sb_leftover", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
